// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder
//   Ping-pong reorder buffer behind the NTT pipeline. Each N-point frame
//   arrives in bit-reversed index order and is re-emitted in natural index
//   order. One bank fills while the other drains, so back-to-back frames
//   stream at one word per cycle without bubbles.
//
// Parameters
//   W        coefficient width in bits
//   N        frame length, power of two, N >= 2
//   MODULUS  field modulus, only used by the optional range check
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready depends on state only
//   in_data            coefficient in bit-reversed order
//   out_valid/out_ready output handshake; out_* depend on state only
//   out_data           coefficient in natural order
//   out_index          natural index of out_data
//   out_last           marks out_index == N-1
//   range_err          sticky flag, input word >= MODULUS
//
// Build option
//   NTT_REORDER_RANGE_CHECK_EN  when defined, every accepted word is compared
//   against MODULUS and range_err latches on a violation. When undefined,
//   range_err is tied low and no comparator exists.

module ntt_bitrev_reorder #(
  parameter int W       = 32,
  parameter int N       = 16,
  parameter int MODULUS = 7681
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_index,
  output logic                   out_last,
  output logic                   range_err
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       full_q, full_d;

  logic             accept;
  logic             rd_fire;
  logic [LOG2N-1:0] wr_addr;
  logic [W-1:0]     rd_word [2];

  always_comb begin
    in_ready  = !full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    accept    = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    wr_addr   = bitrev(wr_cnt_q);

    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;

    // Counters are exactly LOG2N bits, so the increment wraps to 0 on the
    // last word of a frame without extra logic.
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_LAST) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end
    end

    // The writer only touches an empty bank and the reader only a full one,
    // so these two updates can never target the same full_d bit.
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_LAST) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= 2'b00;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
    end
  end

  // Two banks. The read port is asynchronous so out_data follows rd_cnt in
  // the same cycle; banks are cleared on reset so out_data reads 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          mem_q[i] <= '0;
        end
      end else if (accept && (wr_sel_q == 1'(gi))) begin
        mem_q[wr_addr] <= in_data;
      end
    end

    assign rd_word[gi] = mem_q[rd_cnt_q];
  end

  assign out_data  = rd_word[rd_sel_q];
  assign out_index = rd_cnt_q;
  assign out_last  = out_valid && (rd_cnt_q == CNT_LAST);

`ifdef NTT_REORDER_RANGE_CHECK_EN
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
  logic range_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else if (accept && (in_data >= MOD_W)) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
module tb_ntt_bitrev_reorder;

  localparam int W       = 32;
  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int MODULUS = 7681;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             range_err;

  ntt_bitrev_reorder #(.W(W), .N(N), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frames are collected whole, then the expected natural
  // order output list is built by picking word bitrev(j) for position j.
  logic [W-1:0] cur_frame [$];
  logic [W-1:0] exp_q [$];
  int           pending;     // complete frames buffered, not yet fully read
  int           out_pos;     // position within the frame being read
  bit           exp_range;

  // Observed (o_*) and expected (e_*) snapshot of the cycle just stepped.
  logic             o_ready, o_valid, o_last, o_rerr;
  logic [W-1:0]     o_data;
  logic [LOG2N-1:0] o_idx;
  logic             e_ready, e_valid, e_last, e_rerr;
  logic [W-1:0]     e_data;
  logic [LOG2N-1:0] e_idx;
  bit               acc, fire;

  function automatic int bitrev_ref(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_clear();
    cur_frame.delete();
    exp_q.delete();
    pending   = 0;
    out_pos   = 0;
    exp_range = 0;
  endtask

  // One clock cycle: drive at the falling edge, snapshot outputs, let the
  // rising edge happen, then advance the reference model.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    o_ready = in_ready;
    o_valid = out_valid;
    o_data  = out_data;
    o_idx   = out_index;
    o_last  = out_last;
    o_rerr  = range_err;
    e_ready = (pending < 2);
    e_valid = (pending > 0);
    e_data  = (exp_q.size() > 0) ? exp_q[0] : '0;
    e_idx   = LOG2N'(out_pos);
    e_last  = e_valid && (out_pos == N - 1);
    e_rerr  = exp_range;
    acc     = iv && o_ready;
    fire    = o_valid && ordy;
    @(posedge clk);
    #1;
    if (acc && !rst) begin
      cur_frame.push_back(id);
`ifdef NTT_REORDER_RANGE_CHECK_EN
      if (id >= MODULUS) exp_range = 1;
`endif
      if (cur_frame.size() == N) begin
        for (int j = 0; j < N; j++) exp_q.push_back(cur_frame[bitrev_ref(j)]);
        pending++;
        cur_frame.delete();
      end
    end
    if (fire && !rst) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_pos++;
      if (out_pos == N) begin
        out_pos = 0;
        pending--;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    model_clear();
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", o_valid); end
    checks++; if (o_idx !== '0) begin errors++; $display("FAIL rst_out_index got=%0d want=0", o_idx); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b want=0", o_last); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL rst_out_data got=%0d want=0", o_data); end
    checks++; if (o_rerr !== 1'b0) begin errors++; $display("FAIL rst_range_err got=%b want=0", o_rerr); end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int sent = 0, nout = 0, cyc = 0, acc16_cyc = -1, first_valid = -1;
    while (nout < N && cyc < 200) begin
      step(sent < N, W'(sent), 1'b1);
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL sf_valid cyc=%0d got=%b want=%b", cyc, o_valid, e_valid); end
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (fire) begin
        checks++; if (o_data !== W'(tab[nout])) begin errors++; $display("FAIL sf_data pos=%0d got=%0d want=%0d", nout, o_data, tab[nout]); end
        checks++; if (o_idx !== LOG2N'(nout)) begin errors++; $display("FAIL sf_index pos=%0d got=%0d want=%0d", nout, o_idx, nout); end
        checks++; if (o_last !== (nout == N - 1)) begin errors++; $display("FAIL sf_last pos=%0d got=%b want=%b", nout, o_last, nout == N - 1); end
        nout++;
      end
      if (acc) begin
        sent++;
        if (sent == N) acc16_cyc = cyc;
      end
      cyc++;
    end
    checks++; if (nout != N) begin errors++; $display("FAIL sf_timeout got=%0d outputs want=%0d", nout, N); end
    checks++; if (first_valid != acc16_cyc + 1) begin errors++; $display("FAIL sf_latency got=cycle %0d want=cycle %0d", first_valid, acc16_cyc + 1); end
    $display("test_single_frame done: %0d outputs", nout);
  endtask

  task automatic test_back_to_back();
    int sent = 0, nout = 0, cyc = 0;
    bit started = 0;
    while (nout < 3 * N && cyc < 300) begin
      step(sent < 3 * N, W'(sent), 1'b1);
      if (sent < 3 * N) begin
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, o_ready); end
      end
      if (started) begin
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap cyc=%0d got=%b want=1", cyc, o_valid); end
      end
      if (fire) begin
        started = 1;
        checks++;
        if (o_data !== W'(bitrev_ref(nout % N) + N * (nout / N))) begin
          errors++; $display("FAIL b2b_data pos=%0d got=%0d want=%0d", nout, o_data, bitrev_ref(nout % N) + N * (nout / N));
        end
        checks++; if (o_idx !== LOG2N'(nout % N)) begin errors++; $display("FAIL b2b_index pos=%0d got=%0d want=%0d", nout, o_idx, nout % N); end
        nout++;
      end
      if (acc) sent++;
      cyc++;
    end
    checks++; if (nout != 3 * N) begin errors++; $display("FAIL b2b_timeout got=%0d outputs want=%0d", nout, 3 * N); end
    $display("test_back_to_back done: %0d outputs", nout);
  endtask

  task automatic test_backpressure();
    int sent = 0, nout = 0, cyc = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, W'($urandom_range(0, MODULUS - 1)), 1'b0);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL bp_stall_ready cyc=%0d got=%b want=%b", c, o_ready, e_ready); end
      if (acc) sent++;
    end
    checks++; if (sent != 2 * N) begin errors++; $display("FAIL bp_accepts got=%0d want=%0d", sent, 2 * N); end
    while (nout < 3 * N && cyc < 400) begin
      step(sent < 3 * N, W'($urandom_range(0, MODULUS - 1)), 1'b1);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
      if (fire) begin
        checks++; if (o_data !== e_data) begin errors++; $display("FAIL bp_data pos=%0d got=%0d want=%0d", nout, o_data, e_data); end
        nout++;
      end
      if (acc) sent++;
      cyc++;
    end
    checks++; if (nout != 3 * N) begin errors++; $display("FAIL bp_timeout got=%0d outputs want=%0d", nout, 3 * N); end
    $display("test_backpressure done: %0d outputs", nout);
  endtask

  task automatic test_stall_random();
    int sent = 0, nout = 0, cyc = 0;
    logic p_hold = 1'b0, p_last;
    logic [W-1:0] p_data;
    logic [LOG2N-1:0] p_idx;
    logic ordy;
    while (nout < 3 * N && cyc < 2000) begin
      ordy = 1'($urandom_range(0, 1));
      step((sent < 3 * N) && ($urandom_range(0, 3) != 0), W'($urandom_range(0, MODULUS - 1)), ordy);
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL st_valid cyc=%0d got=%b want=%b", cyc, o_valid, e_valid); end
      if (p_hold) begin
        checks++;
        if (o_data !== p_data || o_idx !== p_idx || o_last !== p_last) begin
          errors++; $display("FAIL st_hold cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", cyc, o_data, o_idx, o_last, p_data, p_idx, p_last);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_data !== e_data || o_idx !== e_idx || o_last !== e_last) begin
          errors++; $display("FAIL st_out cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", cyc, o_data, o_idx, o_last, e_data, e_idx, e_last);
        end
      end
      p_hold = o_valid && !ordy;
      p_data = o_data;
      p_idx  = o_idx;
      p_last = o_last;
      if (fire) nout++;
      if (acc) sent++;
      cyc++;
    end
    checks++; if (nout != 3 * N) begin errors++; $display("FAIL st_timeout got=%0d outputs want=%0d", nout, 3 * N); end
    $display("test_stall_random done: %0d outputs in %0d cycles", nout, cyc);
  endtask

  task automatic test_reset_mid_frame();
    int sent = 0, nout = 0, cyc = 0;
    logic [W-1:0] fresh [N];
    while (sent < 7) begin
      step(1'b1, W'($urandom_range(0, MODULUS - 1)), 1'b1);
      if (acc) sent++;
    end
    rst = 1'b1;
    step(1'b0, '0, 1'b1);
    model_clear();
    rst = 1'b0;
    for (int i = 0; i < N; i++) fresh[i] = W'($urandom_range(0, MODULUS - 1));
    sent = 0;
    while (nout < N && cyc < 200) begin
      step(sent < N, (sent < N) ? fresh[sent] : '0, 1'b1);
      if (cyc == 0) begin
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rm_after_rst got=valid %b ready %b want=valid 0 ready 1", o_valid, o_ready); end
      end
      if (fire) begin
        checks++;
        if (o_data !== fresh[bitrev_ref(nout)] || o_idx !== LOG2N'(nout)) begin
          errors++; $display("FAIL rm_out pos=%0d got=%0d/%0d want=%0d/%0d", nout, o_data, o_idx, fresh[bitrev_ref(nout)], nout);
        end
        nout++;
      end
      if (acc) sent++;
      cyc++;
    end
    step(1'b0, '0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_extra_output got=%b want=0", o_valid); end
    checks++; if (nout != N) begin errors++; $display("FAIL rm_timeout got=%0d outputs want=%0d", nout, N); end
    $display("test_reset_mid_frame done: %0d outputs", nout);
  endtask

  task automatic test_range();
    int sent = 0, nout = 0, cyc = 0;
    while (nout < N && cyc < 200) begin
      step(sent < N, (sent == 5) ? W'(MODULUS) : W'(sent + 100), 1'b1);
      checks++; if (o_rerr !== e_rerr) begin errors++; $display("FAIL rc_flag cyc=%0d got=%b want=%b", cyc, o_rerr, e_rerr); end
      if (fire) begin
        checks++; if (o_data !== e_data) begin errors++; $display("FAIL rc_data pos=%0d got=%0d want=%0d", nout, o_data, e_data); end
        nout++;
      end
      if (acc) sent++;
      cyc++;
    end
    step(1'b0, '0, 1'b1);
`ifdef NTT_REORDER_RANGE_CHECK_EN
    checks++; if (o_rerr !== 1'b1) begin errors++; $display("FAIL rc_sticky got=%b want=1", o_rerr); end
`else
    checks++; if (o_rerr !== 1'b0) begin errors++; $display("FAIL rc_disabled got=%b want=0", o_rerr); end
`endif
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    model_clear();
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    checks++; if (o_rerr !== 1'b0) begin errors++; $display("FAIL rc_cleared got=%b want=0", o_rerr); end
    $display("test_range done: %0d outputs", nout);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_stall_random();
    test_reset_mid_frame();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
